// File: rtl/cpu_jtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_jtag_pkg;

    localparam int DEF_DR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;

    // Virtual IR codes understood by the CPU debug module
    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR
    } scan_state_t;

endpackage

// File: rtl/cpu_jtag_scan_master_if.sv
// Command/response bundle between a debug client and the scan master.
// Latency: n/a (wiring only).
// Backpressure: cmd uses valid/ready; rsp is a one-cycle pulse with no ready.
// master: drives cmd_*, observes cmd_ready/rsp_*/busy.
// slave : the scan master side.
interface cpu_jtag_scan_master_if
    import cpu_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic                cmd_ir_only;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic                busy;

    modport master (
        output cmd_valid, cmd_ir, cmd_ir_only, cmd_dr,
        input  cmd_ready, rsp_valid, rsp_dr, busy
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_ir_only, cmd_dr,
        output cmd_ready, rsp_valid, rsp_dr, busy
    );

endinterface

// File: rtl/cpu_jtag_tck_gen.sv
// Test-clock generator: TCK_DIV clk low, TCK_DIV clk high, with rise/fall strobes.
// Latency: first rise TCK_DIV clk after enable goes high.
// Backpressure: none; dropping enable snaps back to the tck-low, divider-0 phase.
// Ports: clk, reset_n, enable in; tck, rise, fall out (strobes mark the clk
// edge on which the tck register changes).
module cpu_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             wrap;

    assign wrap = enable && (div == DIV_W'(TCK_DIV - 1));
    assign rise = wrap && !tck;
    assign fall = wrap && tck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            tck <= 1'b0;
        end else if (!enable) begin
            div <= '0;
            tck <= 1'b0;
        end else if (wrap) begin
            div <= '0;
            tck <= ~tck;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/cpu_jtag_scan_master.sv
// Turns one command into a virtual-JTAG uir/cdr/sdr x N/udr scan and returns TDO.
// Latency: 1 + (DR_WIDTH+3)*2*TCK_DIV clk for a DR scan, 1 + 2*TCK_DIV for IR-only.
// Backpressure: cmd_ready only in IDLE (incl. the rsp_valid cycle); rsp has none.
// Ports: clk, reset_n; bus (slave modport: cmd_*, rsp_*, busy);
// vji_tck/tdi/ir_in/rti/uir/cdr/sdr/udr out, vji_tdo in.
module cpu_jtag_scan_master
    import cpu_jtag_pkg::*;
#(
    parameter int DR_WIDTH = DEF_DR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cpu_jtag_scan_master_if.slave bus,
    output logic                  vji_tck,
    output logic                  vji_tdi,
    input  logic                  vji_tdo,
    output logic [IR_WIDTH-1:0]   vji_ir_in,
    output logic                  vji_rti,
    output logic                  vji_uir,
    output logic                  vji_cdr,
    output logic                  vji_sdr,
    output logic                  vji_udr
);

    localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [DR_WIDTH-1:0] dr_q;
    logic [DR_WIDTH-1:0] shreg;
    logic                ir_only_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic                tck_rise;
    logic                tck_fall;
    logic                accept;
    logic                done;

    // All state changes are gated by tck_fall, so every vji_* output is
    // stable across the following tck rising edge.
    cpu_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state != IDLE),
        .tck     (vji_tck),
        .rise    (tck_rise),
        .fall    (tck_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        done          = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        vji_rti       = 1'b0;
        vji_uir       = 1'b0;
        vji_cdr       = 1'b0;
        vji_sdr       = 1'b0;
        vji_udr       = 1'b0;
        vji_tdi       = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                vji_rti       = 1'b1;
                accept        = bus.cmd_valid;
                if (bus.cmd_valid) state_nxt = UIR;
            end
            UIR: begin
                vji_uir = 1'b1;
                if (tck_fall) begin
                    state_nxt = ir_only_q ? IDLE : CDR;
                    done      = ir_only_q;
                end
            end
            CDR: begin
                vji_cdr = 1'b1;
                if (tck_fall) state_nxt = SDR;
            end
            SDR: begin
                vji_sdr = 1'b1;
                // dr_q is shifted down once per period, so bit 0 is always the
                // bit belonging to the current period.
                vji_tdi = dr_q[0];
                if (tck_fall && (bit_cnt == CNT_W'(DR_WIDTH - 1))) state_nxt = UDR;
            end
            UDR: begin
                vji_udr = 1'b1;
                if (tck_fall) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dr_q          <= '0;
            ir_only_q     <= 1'b0;
            vji_ir_in     <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_dr    <= '0;
        end else begin
            bus.rsp_valid <= done;
            if (accept) begin
                dr_q      <= bus.cmd_dr;
                ir_only_q <= bus.cmd_ir_only;
                vji_ir_in <= bus.cmd_ir;
            end
            if ((state == CDR) && tck_fall) begin
                bit_cnt <= '0;
            end else if ((state == SDR) && tck_fall) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                dr_q    <= dr_q >> 1;
            end
            // First captured bit enters at the top and ends up in bit 0.
            if ((state == SDR) && tck_rise) begin
                shreg <= {vji_tdo, shreg[DR_WIDTH-1:1]};
            end
            if (done) begin
                bus.rsp_dr <= ir_only_q ? '0 : shreg;
            end
        end
    end

endmodule

// File: tb/tb_cpu_jtag_scan_master.sv
// Bench for cpu_jtag_scan_master: directed and random scans against a debug-module
// shift-register model; DUT a runs TCK_DIV=2, DUT b runs TCK_DIV=1.
module tb_cpu_jtag_scan_master;
    import cpu_jtag_pkg::*;

    localparam int W = 38;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cpu_jtag_scan_master_if #(.DR_WIDTH(W), .IR_WIDTH(2)) bus_a ();
    cpu_jtag_scan_master_if #(.DR_WIDTH(W), .IR_WIDTH(2)) bus_b ();

    logic       tck_a, tdi_a, tdo_a, rti_a, uir_a, cdr_a, sdr_a, udr_a;
    logic [1:0] ir_a;
    logic       tck_b, tdi_b, tdo_b, rti_b, uir_b, cdr_b, sdr_b, udr_b;
    logic [1:0] ir_b;

    // Debug-module side DR: presents bit 0 on TDO, shifts TDI in at the top.
    logic [W-1:0] model;
    assign tdo_a = model[0];
    assign tdo_b = 1'b0;

    cpu_jtag_scan_master #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_tdo(tdo_a), .vji_ir_in(ir_a),
        .vji_rti(rti_a), .vji_uir(uir_a), .vji_cdr(cdr_a), .vji_sdr(sdr_a), .vji_udr(udr_a)
    );

    cpu_jtag_scan_master #(.DR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b), .vji_ir_in(ir_b),
        .vji_rti(rti_b), .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command on DUT a, with the DR model preloaded; all expectations are
    // derived from the scan-sequence rules, not from the DUT.
    task automatic run_a(input logic [1:0] ir, input logic ir_only,
                         input logic [W-1:0] dr, input logic [W-1:0] pre);
        int   cyc, n_uir, n_cdr, n_sdr, n_udr, n_rise, exp_lat;
        logic prev_tck, rti_ok;
        logic [W-1:0] rsp_seen;
        exp_lat = ir_only ? (1 + 2 * 2) : (1 + (W + 3) * 2 * 2);
        model   = pre;
        @(negedge clk);
        bus_a.cmd_valid   = 1'b1;
        bus_a.cmd_ir      = ir;
        bus_a.cmd_ir_only = ir_only;
        bus_a.cmd_dr      = dr;
        chk("ready_at_accept", 64'(bus_a.cmd_ready), 64'(1));
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rise = 0;
        prev_tck = 1'b0; rti_ok = 1'b1;
        @(negedge clk);
        cyc = 1;
        // Scribble over the command while busy: it must have been latched.
        bus_a.cmd_valid   = 1'b0;
        bus_a.cmd_ir      = ~ir;
        bus_a.cmd_ir_only = ~ir_only;
        bus_a.cmd_dr      = ~dr;
        chk("ir_in_after_accept", 64'(ir_a), 64'(ir));
        while (bus_a.rsp_valid !== 1'b1 && cyc < 400) begin
            if (uir_a) n_uir++;
            if (cdr_a) n_cdr++;
            if (sdr_a) n_sdr++;
            if (udr_a) n_udr++;
            if (rti_a !== 1'b0) rti_ok = 1'b0;
            if (tck_a && !prev_tck) begin
                n_rise++;
                if (sdr_a) model = {tdi_a, model[W-1:1]};
            end
            prev_tck = tck_a;
            @(negedge clk);
            cyc++;
        end
        rsp_seen = bus_a.rsp_dr;
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("rsp_dr", 64'(rsp_seen), ir_only ? 64'(0) : 64'(pre));
        chk("model_dr", 64'(model), ir_only ? 64'(pre) : 64'(dr));
        chk("uir_clks", 64'(n_uir), 64'(4));
        chk("cdr_clks", 64'(n_cdr), ir_only ? 64'(0) : 64'(4));
        chk("sdr_clks", 64'(n_sdr), ir_only ? 64'(0) : 64'(W * 4));
        chk("udr_clks", 64'(n_udr), ir_only ? 64'(0) : 64'(4));
        chk("tck_rises", 64'(n_rise), ir_only ? 64'(1) : 64'(W + 3));
        chk("rti_low_in_scan", 64'(rti_ok), 64'(1));
        chk("ready_in_rsp", 64'(bus_a.cmd_ready), 64'(1));
        @(negedge clk);
        chk("rsp_one_cycle", 64'(bus_a.rsp_valid), 64'(0));
        chk("rsp_dr_hold", 64'(bus_a.rsp_dr), 64'(rsp_seen));
        chk("ir_in_hold_idle", 64'(ir_a), 64'(ir));
        chk("rti_idle", 64'(rti_a), 64'(1));
    endtask

    initial begin
        int           cyc, nsdr;
        logic         tdi_ok, saw_rsp;
        logic [63:0]  t;
        logic [W-1:0] dr, pre;

        bus_a.cmd_valid = 1'b0; bus_a.cmd_ir = '0; bus_a.cmd_ir_only = 1'b0; bus_a.cmd_dr = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_ir = '0; bus_b.cmd_ir_only = 1'b0; bus_b.cmd_dr = '0;
        model   = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_vji_a", 64'({tck_a, tdi_a, ir_a, rti_a, uir_a, cdr_a, sdr_a, udr_a}), 64'(9'b0_0_00_1_0000));
        chk("reset_vji_b", 64'({tck_b, tdi_b, ir_b, rti_b, uir_b, cdr_b, sdr_b, udr_b}), 64'(9'b0_0_00_1_0000));
        chk("reset_bus_a", 64'({bus_a.rsp_valid, bus_a.busy, bus_a.cmd_ready}), 64'(3'b001));
        chk("reset_rsp_dr_a", 64'(bus_a.rsp_dr), 64'(0));
        chk("reset_bus_b", 64'({bus_b.rsp_valid, bus_b.busy, bus_b.cmd_ready}), 64'(3'b001));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Main DR scan with looped-back model
        run_a(IR_BREAK, 1'b0, 38'h2A_5A5A_5A5A, 38'h15_0F0F_0F0F);

        // IR-only update
        run_a(IR_TRACECTRL, 1'b1, 38'h3F_FFFF_FFFF, 38'h01_2345_6789);
        repeat (5) @(negedge clk);
        chk("ir_only_ir_in_idle", 64'(ir_a), 64'(3));

        // Back-to-back: second command presented during the first rsp_valid cycle
        @(negedge clk);
        bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = IR_TRACEMEM; bus_a.cmd_ir_only = 1'b1;
        @(negedge clk);
        cyc = 1;
        bus_a.cmd_ir = IR_OCIMEM;
        while (bus_a.rsp_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_latency", 64'(cyc), 64'(5));
        chk("b2b_ir_ignored_busy", 64'(ir_a), 64'(IR_TRACEMEM));
        chk("b2b_ready_in_rsp", 64'(bus_a.cmd_ready), 64'(1));
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        chk("b2b_uir_next_clk", 64'({uir_a, tck_a}), 64'(2'b10));
        chk("b2b_ir_in_second", 64'(ir_a), 64'(IR_OCIMEM));
        cyc = 1;
        while (bus_a.rsp_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_second_latency", 64'(cyc), 64'(5));

        // TCK_DIV=1, all-ones payload, TDO tied low
        @(negedge clk);
        bus_b.cmd_valid = 1'b1; bus_b.cmd_ir = IR_OCIMEM; bus_b.cmd_ir_only = 1'b0; bus_b.cmd_dr = '1;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        cyc = 1; nsdr = 0; tdi_ok = 1'b1;
        while (bus_b.rsp_valid !== 1'b1 && cyc < 400) begin
            if (sdr_b) begin
                nsdr++;
                if (tdi_b !== 1'b1) tdi_ok = 1'b0;
            end else if (tdi_b !== 1'b0) begin
                tdi_ok = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("div1_latency", 64'(cyc), 64'(83));
        chk("div1_rsp_dr", 64'(bus_b.rsp_dr), 64'(0));
        chk("div1_sdr_clks", 64'(nsdr), 64'(W * 2));
        chk("div1_tdi", 64'(tdi_ok), 64'(1));

        // Random commands
        for (int i = 0; i < 4; i++) begin
            t   = {$urandom, $urandom};
            dr  = t[W-1:0];
            t   = {$urandom, $urandom};
            pre = t[W-1:0];
            run_a(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), dr, pre);
        end

        // Reset in the high phase of SDR bit 20
        @(negedge clk);
        model = 38'h2B_CAFE_F00D;
        bus_a.cmd_valid = 1'b1; bus_a.cmd_ir = IR_BREAK; bus_a.cmd_ir_only = 1'b0;
        bus_a.cmd_dr = 38'h11_2233_4455;
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        repeat (90) @(negedge clk);
        chk("pre_reset_sdr_tck_high", 64'({sdr_a, tck_a}), 64'(2'b11));
        reset_n = 1'b0;
        #1;
        chk("mid_reset_tck", 64'(tck_a), 64'(0));
        chk("mid_reset_rti_busy", 64'({rti_a, bus_a.busy}), 64'(2'b10));
        @(negedge clk);
        reset_n = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        chk("post_reset_no_rsp", 64'(saw_rsp), 64'(0));
        chk("post_reset_ready", 64'(bus_a.cmd_ready), 64'(1));
        chk("post_reset_rsp_dr", 64'(bus_a.rsp_dr), 64'(0));

        // Recovery scan after reset
        t   = {$urandom, $urandom};
        dr  = t[W-1:0];
        t   = {$urandom, $urandom};
        pre = t[W-1:0];
        run_a(IR_OCIMEM, 1'b0, dr, pre);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
